// File: rtl/writeback_stage.sv
// Writeback arbiter: merges a no-backpressure pipeline result stream with a buffered
// long-unit result stream into one registered register-file write port, plus a busy scoreboard.
module writeback_stage #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LU_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pipe_valid_i,
  input  logic [ADDR_W-1:0]      pipe_addr_i,
  input  logic [DATA_W-1:0]      pipe_data_i,
  input  logic                   lu_valid_i,
  input  logic [ADDR_W-1:0]      lu_addr_i,
  input  logic [DATA_W-1:0]      lu_data_i,
  output logic                   lu_ready_o,
  input  logic                   issue_valid_i,
  input  logic [ADDR_W-1:0]      issue_addr_i,
  input  logic [ADDR_W-1:0]      chk_addr1_i,
  input  logic [ADDR_W-1:0]      chk_addr2_i,
  output logic                   stall_o,
  output logic                   write_en_o,
  output logic [ADDR_W-1:0]      write_addr_o,
  output logic [DATA_W-1:0]      write_data_o,
  output logic [(1<<ADDR_W)-1:0] busy_o,
  output logic                   waw_err_o
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CNT_W = $clog2(LU_DEPTH + 1);

  logic [ADDR_W-1:0] buf_addr [LU_DEPTH];
  logic [DATA_W-1:0] buf_data [LU_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              wb_is_lu;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic pipe_sel;
  logic lu_keep;
  logic buf_empty;
  logic do_pop;
  logic do_bypass;
  logic do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LU_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign lu_ready_o = (count < CNT_W'(LU_DEPTH));
  assign buf_empty  = (count == '0);
  assign pipe_sel   = pipe_valid_i && (pipe_addr_i != '0);
  assign lu_keep    = lu_valid_i && lu_ready_o && (lu_addr_i != '0);
  assign do_pop     = !pipe_sel && !buf_empty;
  assign do_bypass  = !pipe_sel && buf_empty && lu_keep;
  assign do_push    = lu_keep && !do_bypass;

  assign busy_o  = busy;
  assign stall_o = busy[chk_addr1_i] | busy[chk_addr2_i] | (issue_valid_i & busy[issue_addr_i]);

  // Clear from the long-unit write currently on the port, then apply issue so set wins.
  always_comb begin
    busy_nxt = busy;
    if (write_en_o && wb_is_lu) busy_nxt[write_addr_o] = 1'b0;
    if (issue_valid_i && (issue_addr_i != '0)) busy_nxt[issue_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      buf_addr[wr_ptr] <= lu_addr_i;
      buf_data[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      wb_is_lu     <= 1'b0;
      waw_err_o    <= 1'b0;
      busy         <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      busy <= busy_nxt;
      if (pipe_sel) begin
        write_en_o   <= 1'b1;
        write_addr_o <= pipe_addr_i;
        write_data_o <= pipe_data_i;
        wb_is_lu     <= 1'b0;
        if (busy[pipe_addr_i]) waw_err_o <= 1'b1;
      end else if (do_pop) begin
        write_en_o   <= 1'b1;
        write_addr_o <= buf_addr[rd_ptr];
        write_data_o <= buf_data[rd_ptr];
        wb_is_lu     <= 1'b1;
      end else if (do_bypass) begin
        write_en_o   <= 1'b1;
        write_addr_o <= lu_addr_i;
        write_data_o <= lu_data_i;
        wb_is_lu     <= 1'b1;
      end else begin
        write_en_o <= 1'b0;
        wb_is_lu   <= 1'b0;
      end
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run, all checked
// against a queue-based behavioural model of the writeback rules.
module tb_writeback_stage;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int DEP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_valid, lu_valid, issue_valid;
  logic [AW-1:0] pipe_addr, lu_addr, issue_addr, chk1, chk2;
  logic [DW-1:0] pipe_data, lu_data;
  logic          lu_ready, stall, write_en, waw_err;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [7:0]    busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .LU_DEPTH(DEP)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_valid_i(pipe_valid), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .lu_valid_i(lu_valid), .lu_addr_i(lu_addr), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
    .chk_addr1_i(chk1), .chk_addr2_i(chk2), .stall_o(stall),
    .write_en_o(write_en), .write_addr_o(write_addr), .write_data_o(write_data),
    .busy_o(busy), .waw_err_o(waw_err)
  );

  // Reference model: pending long results as a queue, scoreboard as a bit vector.
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t          mq[$];
  logic [7:0]    m_busy;
  logic          m_we, m_wlu, m_waw;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  function automatic void model_edge();
    logic       lu_acc;
    logic [7:0] nb;
    ent_t       e;
    if (rst) begin
      mq.delete();
      m_busy = '0; m_we = 0; m_wlu = 0; m_waw = 0; m_wa = '0; m_wd = '0;
      return;
    end
    nb = m_busy;
    if (m_we && m_wlu) nb[m_wa] = 1'b0;
    if (issue_valid && issue_addr != 0) nb[issue_addr] = 1'b1;
    lu_acc = lu_valid && (mq.size() < DEP) && (lu_addr != 0);
    m_we = 0; m_wlu = 0;
    if (pipe_valid && pipe_addr != 0) begin
      m_we = 1; m_wa = pipe_addr; m_wd = pipe_data;
      if (m_busy[pipe_addr]) m_waw = 1;
      if (lu_acc) mq.push_back('{lu_addr, lu_data});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1; m_wlu = 1; m_wa = e.a; m_wd = e.d;
      if (lu_acc) mq.push_back('{lu_addr, lu_data});
    end else if (lu_acc) begin
      m_we = 1; m_wlu = 1; m_wa = lu_addr; m_wd = lu_data;
    end
    m_busy = nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    pipe_valid = 0; lu_valid = 0; issue_valid = 0;
    pipe_addr = '0; lu_addr = '0; issue_addr = '0; chk1 = '0; chk2 = '0;
    pipe_data = '0; lu_data = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", write_en); end
    checks++; if (write_addr !== 3'd0 || write_data !== 16'd0) begin failures++; $display("FAIL rst_wdata got=%0d/%h exp=0/0", write_addr, write_data); end
    checks++; if (busy !== 8'h00 || waw_err !== 1'b0) begin failures++; $display("FAIL rst_busy got=%h/%b exp=00/0", busy, waw_err); end
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", lu_ready); end
  endtask

  task automatic test_pipe();
    idle(); pipe_valid = 1; pipe_addr = 3; pipe_data = 16'hBEEF; tick();
    checks++; if ({write_en, write_addr, write_data} !== {1'b1, 3'd3, 16'hBEEF}) begin failures++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/3/beef", write_en, write_addr, write_data); end
    pipe_addr = 0; pipe_data = 16'h1111; tick();
    checks++; if ({write_en, write_addr, write_data} !== {1'b0, 3'd3, 16'hBEEF}) begin failures++; $display("FAIL pipe_drop got=%b/%0d/%h exp=0/3/beef", write_en, write_addr, write_data); end
  endtask

  task automatic test_issue_return();
    idle(); issue_valid = 1; issue_addr = 5; tick();
    checks++; if (busy[5] !== 1'b1) begin failures++; $display("FAIL issue_busy got=%b exp=1", busy[5]); end
    idle(); chk1 = 5; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL issue_stall got=%b exp=1", stall); end
    lu_valid = 1; lu_addr = 5; lu_data = 16'h1234; tick();
    checks++; if ({write_en, write_addr, write_data, busy[5]} !== {1'b1, 3'd5, 16'h1234, 1'b1}) begin failures++; $display("FAIL lu_bypass got=%b/%0d/%h busy=%b exp=1/5/1234 busy=1", write_en, write_addr, write_data, busy[5]); end
    lu_valid = 0; tick();
    checks++; if (busy[5] !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL lu_clear got=%b/%b exp=0/0", busy[5], stall); end
  endtask

  task automatic test_conflict_fill();
    logic [2:0] exp_addr [7];
    logic       exp_we   [7];
    logic       exp_rdy  [7];
    exp_addr = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd2, 3'd2};
    exp_we   = '{1, 1, 1, 1, 1, 1, 0};
    exp_rdy  = '{1, 0, 0, 0, 1, 1, 1};
    idle();
    for (int c = 0; c < 7; c++) begin
      pipe_valid = (c < 4); pipe_addr = 7; pipe_data = 16'hA000 + 16'(c);
      lu_valid = (c < 2); lu_addr = 3'(c + 1); lu_data = 16'hC000 + 16'(c + 1);
      tick();
      checks++; if (write_en !== exp_we[c] || write_addr !== exp_addr[c] || lu_ready !== exp_rdy[c]) begin
        failures++; $display("FAIL fill_c%0d got=%b/%0d rdy=%b exp=%b/%0d rdy=%b", c, write_en, write_addr, lu_ready, exp_we[c], exp_addr[c], exp_rdy[c]);
      end
    end
    checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL fill_waw got=%b exp=0", waw_err); end
  endtask

  task automatic test_set_clear();
    idle(); issue_valid = 1; issue_addr = 4; tick();
    idle(); lu_valid = 1; lu_addr = 4; lu_data = 16'h4444; tick();
    idle(); issue_valid = 1; issue_addr = 4; tick();
    checks++; if (busy[4] !== 1'b1) begin failures++; $display("FAIL setclr_busy got=%b exp=1", busy[4]); end
    idle(); tick(); tick();
    checks++; if (busy[4] !== 1'b1) begin failures++; $display("FAIL setclr_hold got=%b exp=1", busy[4]); end
    lu_valid = 1; lu_addr = 4; tick(); idle(); tick();
    checks++; if (busy[4] !== 1'b0) begin failures++; $display("FAIL setclr_final got=%b exp=0", busy[4]); end
  endtask

  task automatic test_waw();
    idle(); issue_valid = 1; issue_addr = 6; tick();
    idle(); pipe_valid = 1; pipe_addr = 6; pipe_data = 16'h0007; tick();
    checks++; if ({write_en, write_addr, write_data, busy[6], waw_err} !== {1'b1, 3'd6, 16'h0007, 1'b1, 1'b1}) begin failures++; $display("FAIL waw_write got=%b/%0d/%h busy=%b waw=%b exp=1/6/0007 busy=1 waw=1", write_en, write_addr, write_data, busy[6], waw_err); end
    idle(); tick(); tick(); tick();
    checks++; if (waw_err !== 1'b1 || busy[6] !== 1'b1) begin failures++; $display("FAIL waw_sticky got=%b/%b exp=1/1", waw_err, busy[6]); end
    rst = 1; tick(); rst = 0;
    checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL waw_reset got=%b exp=0", waw_err); end
  endtask

  task automatic test_reset_flush();
    int wes = 0;
    idle(); issue_valid = 1; issue_addr = 2; tick();
    for (int c = 0; c < 2; c++) begin
      idle(); pipe_valid = 1; pipe_addr = 7; lu_valid = 1; lu_addr = 3'(c + 1); lu_data = 16'(c); tick();
    end
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", lu_ready); end
    idle(); rst = 1; tick(); rst = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (write_en) wes++;
    end
    checks++; if (wes != 0 || busy !== 8'h00 || lu_ready !== 1'b1) begin failures++; $display("FAIL flush_after got writes=%0d busy=%h rdy=%b exp writes=0 busy=00 rdy=1", wes, busy, lu_ready); end
  endtask

  task automatic test_random();
    int errs = 0;
    idle(); rst = 1; tick(); rst = 0;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      pipe_valid  = ($urandom_range(0, 2) == 0);
      pipe_addr   = 3'($urandom);
      pipe_data   = 16'($urandom);
      lu_valid    = ($urandom_range(0, 1) == 0);
      lu_addr     = 3'($urandom);
      lu_data     = 16'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 3'($urandom);
      chk1        = 3'($urandom);
      chk2        = 3'($urandom);
      #1;
      checks++;
      if (stall !== (m_busy[chk1] | m_busy[chk2] | (issue_valid & m_busy[issue_addr])) ||
          lu_ready !== (mq.size() < DEP)) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_comb c=%0d stall=%b rdy=%b exp_rdy=%b", c, stall, lu_ready, (mq.size() < DEP));
      end
      tick();
      checks++;
      if (write_en !== m_we || write_addr !== m_wa || write_data !== m_wd ||
          busy !== m_busy || waw_err !== m_waw) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_regs c=%0d got=%b/%0d/%h busy=%h waw=%b exp=%b/%0d/%h busy=%h waw=%b",
                                c, write_en, write_addr, write_data, busy, waw_err, m_we, m_wa, m_wd, m_busy, m_waw);
      end
    end
    rst = 0;
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_pipe();
    test_issue_return();
    test_conflict_fill();
    test_set_clear();
    test_waw();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
